// File: rtl/fib_detect.sv
// ============================================================================
//  Module      : fib_detect
//  Description : Classifies a 4-bit code as Fibonacci {0,1,2,3,5,8,13} with
//                three independent decoders (gate, dataflow, behavioural),
//                registers the results, flags any disagreement and counts hits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in,
  output logic       out_valid,
  output logic       out_g,
  output logic       out_d,
  output logic       out_b,
  output logic       mismatch,
  output logic [7:0] hit_count
);

  localparam logic [7:0] C_HIT_MAX = 8'hFF;

  // Gate-level decoder: f = a'b' + b'c'd' + bc'd
  wire w_na, w_nb, w_nc, w_nd;
  wire w_t0, w_t1, w_t2;
  wire w_gate_f;

  not u_not_a (w_na, in[3]);
  not u_not_b (w_nb, in[2]);
  not u_not_c (w_nc, in[1]);
  not u_not_d (w_nd, in[0]);
  and u_and_t0 (w_t0, w_na, w_nb);
  and u_and_t1 (w_t1, w_nb, w_nc, w_nd);
  and u_and_t2 (w_t2, in[2], w_nc, in[0]);
  or  u_or_f  (w_gate_f, w_t0, w_t1, w_t2);

  // Dataflow decoder written as a range/compare form, not the gate equation
  wire w_data_f;
  assign w_data_f = (in < 4'd4) | (in == 4'd5) | (in == 4'd8) | (in == 4'd13);

  logic w_beh_f;
  always_comb begin
    w_beh_f = 1'b0;
    case (in)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: w_beh_f = 1'b1;
      default:                                   w_beh_f = 1'b0;
    endcase
  end

  logic       out_valid_q;
  logic       out_g_q, out_d_q, out_b_q;
  logic       mismatch_q, mismatch_d;
  logic [7:0] hit_q, hit_d;
  logic       w_disagree;

  assign w_disagree = (w_gate_f != w_data_f) | (w_data_f != w_beh_f);

  always_comb begin
    mismatch_d = mismatch_q;
    hit_d      = hit_q;
    if (in_valid) begin
      if (w_disagree)
        mismatch_d = 1'b1;
      // Counter follows the behavioural result even after a disagreement
      if (w_beh_f && (hit_q != C_HIT_MAX))
        hit_d = hit_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_g_q     <= 1'b0;
      out_d_q     <= 1'b0;
      out_b_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      hit_q       <= 8'd0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_g_q <= w_gate_f;
        out_d_q <= w_data_f;
        out_b_q <= w_beh_f;
      end
      mismatch_q <= mismatch_d;
      hit_q      <= hit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_g     = out_g_q;
  assign out_d     = out_d_q;
  assign out_b     = out_b_q;
  assign mismatch  = mismatch_q;
  assign hit_count = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_detect.sv
// ============================================================================
//  Module      : tb_fib_detect
//  Description : Directed self-checking bench for fib_detect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_detect;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in;
  logic       out_valid, out_g, out_d, out_b, mismatch;
  logic [7:0] hit_count;

  int total;
  int bad;

  // Bit n set when n is in {0,1,2,3,5,8,13}
  logic [15:0] fib_tbl;

  fib_detect dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out_g     (out_g),
    .out_d     (out_d),
    .out_b     (out_b),
    .mismatch  (mismatch),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in = 4'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in = 4'd3;
    step();
    step();
    total++;
    if ({out_valid, out_g, out_d, out_b, mismatch, hit_count} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b g=%b d=%b b=%b mm=%b hit=%0d, want all 0",
               out_valid, out_g, out_d, out_b, mismatch, hit_count);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    // First capture happens on the first edge after release with in_valid=1
    in = 4'd13;
    in_valid = 1'b1;
    step();
    total++;
    if ({out_valid, out_b, hit_count} !== {1'b1, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL first_capture: got v=%b b=%b hit=%0d, want v=1 b=1 hit=1",
               out_valid, out_b, hit_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic e;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      in = 4'(v);
      in_valid = 1'b1;
      step();
      e = fib_tbl[v];
      total++;
      if ({out_g, out_d, out_b, out_valid, mismatch} !== {e, e, e, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL sweep_%0d: got g=%b d=%b b=%b v=%b mm=%b, want g=d=b=%b v=1 mm=0",
                 v, out_g, out_d, out_b, out_valid, mismatch, e);
      end
    end
    in_valid = 1'b0;
    total++;
    if (hit_count !== 8'd7) begin
      bad++;
      $display("FAIL sweep_hits: got %0d, want 7", hit_count);
    end
  endtask

  task automatic test_hold();
    // Continues from sweep: hit_count is 7
    in = 4'd4;
    in_valid = 1'b1;
    step();
    in = 4'd13;
    in_valid = 1'b0;
    step();
    total++;
    if ({out_g, out_d, out_b, out_valid, hit_count} !== {4'b0000, 8'd7}) begin
      bad++;
      $display("FAIL hold: got g=%b d=%b b=%b v=%b hit=%0d, want 0 0 0 0 7",
               out_g, out_d, out_b, out_valid, hit_count);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    do_reset();
    in = 4'd5;
    in_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      e = (i > 255) ? 8'd255 : 8'(i);
      total++;
      if (hit_count !== e) begin
        bad++;
        $display("FAIL saturate_%0d: got %0d, want %0d", i, hit_count, e);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    // Counter is saturated here; force mismatch too? no, just assert reset mid-cycle
    in_valid = 1'b1;
    in = 4'd5;
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_g, out_d, out_b, mismatch, hit_count} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b g=%b d=%b b=%b mm=%b hit=%0d, want all 0",
               out_valid, out_g, out_d, out_b, mismatch, hit_count);
    end
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fault();
    do_reset();
    force dut.w_gate_f = 1'b0;
    in = 4'd8;
    in_valid = 1'b1;
    step();
    total++;
    if ({mismatch, out_g, out_d, out_b, hit_count} !== {4'b1011, 8'd1}) begin
      bad++;
      $display("FAIL fault_set: got mm=%b g=%b d=%b b=%b hit=%0d, want mm=1 g=0 d=1 b=1 hit=1",
               mismatch, out_g, out_d, out_b, hit_count);
    end
    release dut.w_gate_f;
    in = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({mismatch, out_g} !== 2'b11) begin
        bad++;
        $display("FAIL fault_sticky_%0d: got mm=%b g=%b, want mm=1 g=1", i, mismatch, out_g);
      end
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({mismatch, hit_count} !== 9'd0) begin
      bad++;
      $display("FAIL fault_clear: got mm=%b hit=%0d, want 0 0", mismatch, hit_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = (i % 2 == 0) ? 4'd12 : 4'd13;
      e = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      total++;
      if ({out_g, out_d, out_b, out_valid} !== {e, e, e, 1'b1}) begin
        bad++;
        $display("FAIL b2b_%0d: got g=%b d=%b b=%b v=%b, want %b %b %b 1",
                 i, out_g, out_d, out_b, out_valid, e, e, e);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if ({hit_count, mismatch} !== {8'd4, 1'b0}) begin
      bad++;
      $display("FAIL b2b_hits: got hit=%0d mm=%b, want hit=4 mm=0", hit_count, mismatch);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    fib_tbl = 16'h212F;
    rst = 1'b1;
    in_valid = 1'b0;
    in = 4'd0;
    test_reset();
    test_sweep();
    test_hold();
    test_saturate();
    test_async_reset();
    test_fault();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fib_detect.md
FIB_DETECT -- requirements
Module: fib_detect

Interface
REQ-001 Parameters: none; input width fixed at 4 bits, count width fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  qualifies in for the current cycle.
REQ-005 in  input  4  unsigned code under test, 0..15.
REQ-006 out_valid  output  1  registered copy of in_valid.
REQ-007 out_g  output  1  registered result of the gate-level decoder.
REQ-008 out_d  output  1  registered result of the dataflow decoder.
REQ-009 out_b  output  1  registered result of the behavioural decoder.
REQ-010 mismatch  output  1  sticky flag: decoders have disagreed since reset.
REQ-011 hit_count  output  8  saturating count of valid samples classified Fibonacci.

Function
REQ-012 Fibonacci set F = {0,1,2,3,5,8,13}; the decoder output SHALL be 1 iff in is in F, and 0 for 4,6,7,9,10,11,12,14,15.
REQ-013 Gate decoder SHALL be built from primitive gate instances only: f = a'b' + b'c'd' + bc'd, where a=in[3], b=in[2], c=in[1], d=in[0].
REQ-014 Dataflow decoder SHALL be a single continuous boolean assignment that is independent of the gate netlist.
REQ-015 Behavioural decoder SHALL be a procedural case/lookup over all 16 codes, with a default of 0.
REQ-016 All three decoders SHALL be purely combinational and SHALL be evaluated in parallel.
REQ-017 On each rising clk edge with in_valid=1: out_g, out_d and out_b SHALL capture their decoder values; latency is 1 cycle.
REQ-018 With in_valid=0: out_g, out_d and out_b SHALL hold their previous values; out_valid SHALL go to 0 on the next edge.
REQ-019 mismatch SHALL set on the edge after any valid sample where the three decoder values are not all equal.
REQ-020 mismatch SHALL clear only on rst.
REQ-021 hit_count SHALL increment by 1 on each valid sample whose behavioural result is 1.
REQ-022 hit_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-023 hit_count SHALL use the behavioural result as its reference, even when mismatch is set.
REQ-024 Inputs X/Z are out of scope; no defined response is required for them.

Reset
REQ-025 While rst=1, independent of clk: out_valid, out_g, out_d, out_b and mismatch SHALL be 0, and hit_count SHALL be 0.
REQ-026 Asserting rst mid-stream SHALL immediately clear all state, including a saturated counter and a set mismatch flag.
REQ-027 The first capture after reset release SHALL occur on the first rising edge with rst=0 and in_valid=1.

Verification
REQ-028 Sweep in=0..15 with in_valid=1, one value per cycle -> out_g=out_d=out_b=1 exactly for 0,1,2,3,5,8,13, one cycle later; mismatch=0 throughout; hit_count=7 at the end.
REQ-029 in=4, in_valid=1 then in=13, in_valid=0 -> outputs stay 0 (from code 4); out_valid=0; hit_count unchanged.
REQ-030 Apply 300 consecutive valid samples of in=5 -> hit_count reaches 255 and stays there.
REQ-031 Assert rst asynchronously between clock edges with hit_count=255 -> all outputs read 0 before the next edge.
REQ-032 Force the gate decoder output to 0 for in=8 (fault injection) -> mismatch=1 on the next edge and stays 1 until rst.
REQ-033 Back-to-back alternating in=12 / in=13 valid samples -> outputs toggle 0/1 each cycle with 1-cycle latency.
